// File: rtl/axe_clk_mon_pkg.sv
// Shared types and helpers for the clock frequency monitor.
package axe_clk_mon_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    // Widest counter the difference helper supports (CNT_W must not exceed this).
    localparam int unsigned MAX_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } mon_state_e;

    function automatic logic [MAX_W:0] abs_diff(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
        logic [MAX_W:0] wa;
        logic [MAX_W:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return (wa >= wb) ? (wa - wb) : (wb - wa);
    endfunction

endpackage

// File: rtl/axe_clk_mon_sync.sv
// Multi-flop synchronizer for the monitored clock plus rise/fall detection on the synchronized level.
module axe_clk_mon_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mon_clk,
    output logic rise,
    output logic fall,
    output logic s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        s    = sync_q[SYNC_STAGES-1];
        rise = s & ~s_d;
        fall = ~s & s_d;
    end

endmodule

// File: rtl/axe_clk_freq_monitor.sv
// Measures period and high time of i_mon_clk in i_clk cycles and flags period/duty/stopped errors.
// Optional assertion and error-report block: define AXE_CLK_FREQ_MON_SVA_EN.
module axe_clk_freq_monitor
    import axe_clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned SETTLE_EDGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_mon_clk,
    input  logic [CNT_W-1:0] i_exp_period,
    input  logic [CNT_W-1:0] i_exp_high,
    input  logic [CNT_W-1:0] i_tol,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_period_err,
    output logic             o_duty_err,
    output logic             o_clk_stopped,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int unsigned SET_W = $clog2(SETTLE_EDGES + 1);

    mon_state_e       state;
    mon_state_e       state_nxt;
    logic             rise;
    logic             fall;
    logic             s;
    logic [CNT_W-1:0] cnt_pd;
    logic [CNT_W-1:0] cnt_hi;
    logic [CNT_W-1:0] hi_lat;
    logic [CNT_W-1:0] meas_high;
    logic             fall_seen;
    logic [SET_W-1:0] settle_cnt;
    logic             run;
    logic             measuring;
    logic             clr_count;
    logic             settle_done;
    logic [CNT_W:0]   pd_diff;
    logic [CNT_W:0]   hi_diff;
    logic             publish;
    logic             period_bad;
    logic             duty_bad;
    logic             timeout_hit;
    logic             err_event;

    axe_clk_mon_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .mon_clk(i_mon_clk),
        .rise   (rise),
        .fall   (fall),
        .s      (s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_SETTLE;
                ST_SETTLE:  if (settle_done) state_nxt = ST_MEASURE;
                ST_MEASURE: state_nxt = ST_MEASURE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        run         = (state != ST_IDLE);
        measuring   = (state == ST_MEASURE) && i_enable;
        clr_count   = (state == ST_IDLE) && i_enable;
        settle_done = (state == ST_SETTLE) && rise && (settle_cnt == SET_W'(SETTLE_EDGES - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_pd     <= '0;
            cnt_hi     <= '0;
            hi_lat     <= '0;
            fall_seen  <= 1'b0;
            settle_cnt <= '0;
        end else if (!run) begin
            cnt_pd     <= '0;
            cnt_hi     <= '0;
            hi_lat     <= '0;
            fall_seen  <= 1'b0;
            settle_cnt <= '0;
        end else begin
            if (rise) begin
                cnt_pd <= CNT_W'(1);
            end else if (cnt_pd != '1) begin
                cnt_pd <= cnt_pd + 1'b1;
            end
            if (rise) begin
                cnt_hi <= CNT_W'(1);
            end else if (s && (cnt_hi != '1)) begin
                cnt_hi <= cnt_hi + 1'b1;
            end
            if (fall) begin
                hi_lat    <= cnt_hi;
                fall_seen <= 1'b1;
            end else if (rise) begin
                fall_seen <= 1'b0;
            end
            if ((state == ST_SETTLE) && rise) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // A rise with no fall since the previous rise means the clock never went low: report 100% duty.
    always_comb begin
        meas_high   = fall_seen ? hi_lat : cnt_pd;
        pd_diff     = (CNT_W+1)'(abs_diff(MAX_W'(cnt_pd), MAX_W'(i_exp_period)));
        hi_diff     = (CNT_W+1)'(abs_diff(MAX_W'(meas_high), MAX_W'(i_exp_high)));
        publish     = measuring && rise;
        period_bad  = pd_diff > {1'b0, i_tol};
        duty_bad    = (i_exp_high != '0) && (hi_diff > {1'b0, i_tol});
        timeout_hit = measuring && !rise && !o_clk_stopped && ({1'b0, cnt_pd} >= {i_exp_period, 1'b0});
        err_event   = (publish && (period_bad || duty_bad)) || timeout_hit;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_period     <= '0;
            o_high       <= '0;
            o_valid      <= 1'b0;
            o_period_err <= 1'b0;
            o_duty_err   <= 1'b0;
        end else begin
            o_valid      <= publish;
            o_period_err <= publish && period_bad;
            o_duty_err   <= publish && duty_bad;
            if (publish) begin
                o_period <= cnt_pd;
                o_high   <= meas_high;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_clk_stopped <= 1'b0;
            o_err_count   <= '0;
        end else begin
            if (!measuring || rise) begin
                o_clk_stopped <= 1'b0;
            end else if (timeout_hit) begin
                o_clk_stopped <= 1'b1;
            end
            if (clr_count) begin
                o_err_count <= '0;
            end else if (err_event && (o_err_count != '1)) begin
                o_err_count <= o_err_count + 1'b1;
            end
        end
    end

`ifdef AXE_CLK_FREQ_MON_SVA_EN
    if ((SYNC_STAGES < 2) || (SETTLE_EDGES < 1)) begin : g_param_chk
        $error("axe_clk_freq_monitor: SYNC_STAGES=%0d (min 2) SETTLE_EDGES=%0d (min 1)",
               SYNC_STAGES, SETTLE_EDGES);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && publish && period_bad)
            $error("%t axe_clk_freq_monitor period error: measured=%0d expected=%0d tol=%0d",
                   $time, cnt_pd, i_exp_period, i_tol);
        if (i_rst_n && publish && duty_bad)
            $error("%t axe_clk_freq_monitor duty error: measured=%0d expected=%0d tol=%0d",
                   $time, meas_high, i_exp_high, i_tol);
        if (i_rst_n && timeout_hit)
            $error("%t axe_clk_freq_monitor clock stopped: count=%0d expected period=%0d",
                   $time, cnt_pd, i_exp_period);
    end

    a_valid_in_measure: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_valid |-> (state == ST_MEASURE))
        else $error("%t axe_clk_freq_monitor o_valid outside MEASURE", $time);
`endif

endmodule

// File: tb/tb_axe_clk_freq_monitor.sv
// Directed, table-driven bench for axe_clk_freq_monitor; 4 time units represent one i_clk cycle.
module tb_axe_clk_freq_monitor;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         mon_clk;
    logic [W-1:0] exp_period;
    logic [W-1:0] exp_high;
    logic [W-1:0] tol;
    logic [W-1:0] o_period;
    logic [W-1:0] o_high;
    logic         o_valid;
    logic         o_period_err;
    logic         o_duty_err;
    logic         o_clk_stopped;
    logic [W-1:0] o_err_count;

    int  n_pass = 0;
    int  n_total = 0;
    int  mon_hi = 5;
    int  mon_lo = 5;
    bit  mon_run = 1'b0;
    int  raw_rises = 0;

    typedef struct {
        int           hi;
        int           lo;
        logic [W-1:0] e_period;
        logic [W-1:0] e_high;
        logic [W-1:0] e_tol;
        logic [W-1:0] x_period;
        logic [W-1:0] x_high;
        logic         x_perr;
        logic         x_derr;
    } vec_t;

    vec_t vecs[9];

    axe_clk_freq_monitor #(
        .CNT_W       (W),
        .SYNC_STAGES (2),
        .SETTLE_EDGES(2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_mon_clk    (mon_clk),
        .i_exp_period (exp_period),
        .i_exp_high   (exp_high),
        .i_tol        (tol),
        .o_period     (o_period),
        .o_high       (o_high),
        .o_valid      (o_valid),
        .o_period_err (o_period_err),
        .o_duty_err   (o_duty_err),
        .o_clk_stopped(o_clk_stopped),
        .o_err_count  (o_err_count)
    );

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    // Monitored clock edges sit one unit before each reference posedge, never on it.
    initial begin
        mon_clk = 1'b0;
        #1;
        forever begin
            if (mon_run) begin
                mon_clk = 1'b1;
                #(mon_hi * 4);
                mon_clk = 1'b0;
                #(mon_lo * 4);
            end else begin
                mon_clk = 1'b0;
                #4;
            end
        end
    end

    always @(posedge mon_clk) raw_rises++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_valids(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
    endtask

    task automatic setup(input int hi, input int lo, input logic [W-1:0] ep,
                         input logic [W-1:0] eh, input logic [W-1:0] et);
        enable = 1'b0;
        mon_hi = hi;
        mon_lo = lo;
        exp_period = ep;
        exp_high = eh;
        exp_period = ep;
        tol = et;
        cycles(30);
        enable = 1'b1;
    endtask

    initial begin
        bit got;
        int seen;

        vecs[0] = '{5, 5, 16'd10, 16'd5, 16'd1, 16'd10, 16'd5, 1'b0, 1'b0};
        vecs[1] = '{4, 4, 16'd10, 16'd7, 16'd1, 16'd8,  16'd4, 1'b1, 1'b1};
        vecs[2] = '{3, 7, 16'd10, 16'd5, 16'd1, 16'd10, 16'd3, 1'b0, 1'b1};
        vecs[3] = '{4, 4, 16'd10, 16'd5, 16'd1, 16'd8,  16'd4, 1'b1, 1'b0};
        vecs[4] = '{5, 5, 16'd10, 16'd0, 16'd0, 16'd10, 16'd5, 1'b0, 1'b0};
        vecs[5] = '{6, 5, 16'd10, 16'd5, 16'd1, 16'd11, 16'd6, 1'b0, 1'b0};
        vecs[6] = '{6, 6, 16'd10, 16'd5, 16'd1, 16'd12, 16'd6, 1'b1, 1'b0};
        vecs[7] = '{5, 5, 16'd12, 16'd7, 16'd1, 16'd10, 16'd5, 1'b1, 1'b1};
        vecs[8] = '{5, 4, 16'd10, 16'd5, 16'd1, 16'd9,  16'd5, 1'b0, 1'b0};

        rst_n = 1'b0;
        enable = 1'b0;
        exp_period = 16'd10;
        exp_high = 16'd5;
        tol = 16'd1;
        mon_run = 1'b1;
        cycles(5);
        chk("rst_period", o_period, 0);
        chk("rst_high", o_high, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_flags", {o_period_err, o_duty_err, o_clk_stopped}, 0);
        chk("rst_errcnt", o_err_count, 0);
        rst_n = 1'b1;
        cycles(3);

        for (int v = 0; v < 9; v++) begin
            setup(vecs[v].hi, vecs[v].lo, vecs[v].e_period, vecs[v].e_high, vecs[v].e_tol);
            cycles(3);
            chk("enable_clears_errcnt", o_err_count, 0);
            for (int k = 1; k <= 3; k++) begin
                wait_valid(100, got);
                chk("valid_seen", got, 1);
                chk("period", o_period, vecs[v].x_period);
                chk("high", o_high, vecs[v].x_high);
                chk("period_err", o_period_err, vecs[v].x_perr);
                chk("duty_err", o_duty_err, vecs[v].x_derr);
            end
            chk("err_count", o_err_count, (vecs[v].x_perr | vecs[v].x_derr) ? 3 : 0);
        end

        // Settle: start the monitored clock only after enable so every rise is seen in SETTLE.
        enable = 1'b0;
        mon_run = 1'b0;
        mon_hi = 5;
        mon_lo = 5;
        exp_period = 16'd10;
        exp_high = 16'd5;
        tol = 16'd1;
        cycles(30);
        enable = 1'b1;
        cycles(5);
        raw_rises = 0;
        mon_run = 1'b1;
        wait_valid(100, got);
        chk("settle_valid_seen", got, 1);
        chk("settle_rises_before_valid", raw_rises, 3);
        chk("settle_period", o_period, 10);

        // Stopped clock: timeout after 2x expected period, counted once, cleared by next rise.
        wait_valid(100, got);
        chk("pre_stop_valid", got, 1);
        mon_run = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_clk_stopped) begin
                got = 1'b1;
                break;
            end
        end
        chk("stopped_set", got, 1);
        chk("stopped_errcnt", o_err_count, 1);
        cycles(30);
        chk("stopped_sticky", o_clk_stopped, 1);
        chk("stopped_errcnt_once", o_err_count, 1);
        chk("stopped_period_held", o_period, 10);
        mon_run = 1'b1;
        wait_valid(100, got);
        chk("restart_valid_seen", got, 1);
        chk("restart_stopped_cleared", o_clk_stopped, 0);
        chk("restart_period_err", o_period_err, 1);
        chk("restart_errcnt", o_err_count, 2);

        // Disable mid-period: no publish, results retained.
        wait_valid(100, got);
        chk("pre_disable_valid", got, 1);
        chk("pre_disable_period", o_period, 10);
        cycles(3);
        enable = 1'b0;
        count_valids(30, seen);
        chk("disable_no_valid", seen, 0);
        chk("disable_period_held", o_period, 10);
        chk("disable_high_held", o_high, 5);
        chk("disable_stopped", o_clk_stopped, 0);

        // Async reset mid-measurement, then resettle with enable held.
        setup(4, 4, 16'd10, 16'd7, 16'd1);
        wait_valid(100, got);
        chk("prereset_valid", got, 1);
        chk("prereset_errcnt", o_err_count, 1);
        cycles(3);
        rst_n = 1'b0;
        #1;
        chk("midrst_period", o_period, 0);
        chk("midrst_high", o_high, 0);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_flags", {o_period_err, o_duty_err, o_clk_stopped}, 0);
        chk("midrst_errcnt", o_err_count, 0);
        cycles(5);
        rst_n = 1'b1;
        count_valids(15, seen);
        chk("postrst_settle_no_valid", seen, 0);
        wait_valid(80, got);
        chk("postrst_valid_seen", got, 1);
        chk("postrst_period", o_period, 8);
        chk("postrst_high", o_high, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axe_clk_freq_monitor.md
Name: axe_clk_freq_monitor

Overview:
- DV-side consumer of a generated clock: oversamples a monitored clock (the clock-generator output) in a faster reference clock domain.
- Measures the period and high time in reference cycles and compares them against programmed expectations.
- Flags period, duty and stopped-clock errors, and keeps a saturating error count.
- Sits directly downstream of the clock generator in common DV benches.

Parameters:
- CNT_W, 16, width of all cycle counters, expectations and results
- SYNC_STAGES, 2, synchronizer flops on i_mon_clk (min 2)
- SETTLE_EDGES, 2, rising edges discarded after enable before measuring (min 1)

Ports:
- i_clk  in  1  reference sampling clock; must be faster than 2x the monitored frequency (not checked)
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  level; monitor active while high
- i_mon_clk  in  1  monitored clock, asynchronous to i_clk
- i_exp_period  in  CNT_W  expected period in i_clk cycles
- i_exp_high  in  CNT_W  expected high time in i_clk cycles; 0 disables the duty check
- i_tol  in  CNT_W  allowed absolute deviation, applied to both checks
- o_period  out  CNT_W  last measured period
- o_high  out  CNT_W  last measured high time
- o_valid  out  1  1-cycle pulse when o_period/o_high update
- o_period_err  out  1  1-cycle pulse, qualified with o_valid
- o_duty_err  out  1  1-cycle pulse, qualified with o_valid
- o_clk_stopped  out  1  sticky level, set on timeout, cleared by next detected rise or by leaving MEASURE
- o_err_count  out  CNT_W  saturating count of error events

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 0.
- Sync/edge detect: i_mon_clk passes through SYNC_STAGES flops (s), plus one delay flop (s_d).
  - rise = s & ~s_d; fall = ~s & s_d.
  - Detection latency is SYNC_STAGES+1 i_clk cycles after the real edge.
- cnt_pd: set to 1 on a rise cycle, else +1; saturates at all-ones.
- cnt_hi: set to 1 on a rise cycle; +1 while s=1; frozen on fall and latched to hi_lat; saturates.
- FSM states: IDLE, SETTLE, MEASURE.
  - IDLE: counters held at 0. i_enable=1 -> SETTLE next cycle, and o_err_count cleared on that transition.
  - SETTLE: counts detected rises. The SETTLE_EDGES-th rise -> MEASURE; that rise restarts cnt_pd and publishes nothing.
  - MEASURE, on each rise: next cycle o_period=cnt_pd value before restart, o_high=hi_lat, o_valid=1.
    - o_period_err=1 if |o_period - i_exp_period| > i_tol.
    - o_duty_err=1 if i_exp_high!=0 and |o_high - i_exp_high| > i_tol.
    - Differences are computed CNT_W+1 bits wide and unsigned-safe.
  - Any state: i_enable=0 -> IDLE next cycle. o_period/o_high hold their last values; o_clk_stopped cleared.
- Timeout (MEASURE only): cnt_pd >= 2*i_exp_period, compared CNT_W+1 wide, with o_clk_stopped=0 -> o_clk_stopped=1. Counted once per stall.
- Rise without a preceding fall since the last rise: o_high = o_period (duty 100%).
- o_err_count: +1 per cycle in which any error event occurs (multiple same-cycle events count 1); saturates at all-ones.
- Changes to i_exp_*/i_tol take effect at the next comparison; no reset of measurement.
- Async reset asserted mid-measurement: immediate return to reset state; no partial result published.

Optional Feature:
- Macro: AXE_CLK_FREQ_MON_SVA_EN.
- Defined: compiles in an assertion/reporting block:
  - $error with %t and the measured/expected values on each error event.
  - Assertion that o_valid never pulses outside MEASURE.
  - Assertion that SYNC_STAGES>=2 and SETTLE_EDGES>=1 at elaboration.
- Undefined: no assertions or messages; port behaviour identical.

Decomposition:
- Package axe_clk_mon_pkg: state enum (IDLE, SETTLE, MEASURE), default CNT_W, and an absolute-difference function with a CNT_W+1 result.
- One sub-module, axe_clk_mon_sync: a SYNC_STAGES-deep synchronizer plus edge detector, outputting rise, fall and s.

Test Plan:
- i_clk 1 GHz, mon 100 MHz 50%, exp_period=10, exp_high=5, tol=1 -> o_valid every 10 cycles, o_period=10, o_high=5, no errors, o_err_count=0.
- Mon clock switched to 125 MHz 50% with expectations unchanged -> o_period=8, o_period_err=1 and o_duty_err=1 (|4-5|=1 is within tol, so exp_high=7 is used here) on each valid; o_err_count increments per valid.
- Mon clock held low after enable, exp_period=10 -> o_clk_stopped=1 once cnt_pd reaches 20, o_err_count=1, stays 1. Restart mon clock -> cleared on first detected rise.
- i_enable 0->1 -> first SETTLE_EDGES=2 rises produce no o_valid; first o_valid on the 3rd rise. i_enable=0 mid-period -> IDLE, no o_valid, o_period retains last value.
- Mon 100 MHz 30% duty, exp_high=5, tol=1 -> o_high=3, o_duty_err=1, o_period_err=0.
- Assert i_rst_n=0 mid-period in MEASURE -> all outputs 0 immediately. After release with enable held, settles again before the first o_valid.
